// File: rtl/dsack_generator.sv
// dsack_generator: turns CPU address strobes plus decoded chip selects into
// registered DSACK/BERR bus-cycle terminations. Each channel has its own
// wait-state count and port size, or it can defer to an external slave.
// A watchdog raises bus error on cycles that nobody acknowledges.
module dsack_generator #(
    parameter int               NCH     = 4,
    parameter logic [NCH*4-1:0] WAITS   = '0,
    parameter logic [NCH*2-1:0] PORT    = '0,
    parameter logic [NCH-1:0]   EXTACK  = '0,
    parameter logic [7:0]       TIMEOUT = 8'd255
) (
    input  logic           CLK,
    input  logic           RST_n,
    input  logic           AS_n,
    input  logic           INH,
    input  logic [NCH-1:0] CS_n,
    input  logic           EXT_DSACK0_n,
    input  logic           EXT_DSACK1_n,
    output logic           DSACK0_n,
    output logic           DSACK1_n,
    output logic           BERR_n,
    output logic           BUSY
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {IDLE, WAIT, EXT, ACK, TERM} state_t;

    state_t          state_reg, state_next;
    logic [3:0]      wait_cnt_reg, wait_cnt_next;
    logic [7:0]      wdog_reg, wdog_next, wdog_inc;
    logic [CW-1:0]   chan_reg, chan_next;
    logic            chan_valid_reg, chan_valid_next;
    logic            as_prev_reg;
    logic            dsack0_n_reg, dsack0_n_next;
    logic            dsack1_n_reg, dsack1_n_next;
    logic            berr_n_reg, berr_n_next;

    logic [3:0]      wait_of [NCH];
    logic [1:0]      port_of [NCH];
    logic            ext_of  [NCH];
    logic            sel_found;
    logic [CW-1:0]   sel_idx;

    // Unpack the per-channel configuration vectors into indexable tables.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign wait_of[gi] = WAITS[4*gi +: 4];
            assign port_of[gi] = PORT[2*gi +: 2];
            assign ext_of[gi]  = EXTACK[gi];
        end
    endgenerate

    // Strobe pattern {DSACK1_n, DSACK0_n} for a port size; reserved acts as 8-bit.
    function automatic logic [1:0] port_strobes(input logic [1:0] p);
        case (p)
            2'b01:   return 2'b01;
            2'b10:   return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    assign wdog_inc = wdog_reg + 8'd1;

    // Lowest-index asserted chip select wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!CS_n[i]) begin
                sel_found = 1'b1;
                sel_idx   = CW'(i);
            end
        end
    end

    // Next-state and registered-output logic; outputs are computed from the
    // transition so that they change on the same edge as the state.
    always_comb begin
        state_next      = state_reg;
        wait_cnt_next   = wait_cnt_reg;
        wdog_next       = wdog_reg;
        chan_next       = chan_reg;
        chan_valid_next = chan_valid_reg;
        dsack0_n_next   = dsack0_n_reg;
        dsack1_n_next   = dsack1_n_reg;
        berr_n_next     = berr_n_reg;
        case (state_reg)
            IDLE: begin
                wdog_next     = 8'd0;
                dsack0_n_next = 1'b1;
                dsack1_n_next = 1'b1;
                berr_n_next   = 1'b1;
                // Only a fresh falling sample starts a cycle (matters after reset).
                if (!AS_n && as_prev_reg) begin
                    if (INH) begin
                        state_next = TERM;
                    end else begin
                        chan_next       = sel_idx;
                        chan_valid_next = sel_found;
                        wait_cnt_next   = 4'd0;
                        if (!sel_found) begin
                            state_next = WAIT;
                        end else if (ext_of[sel_idx]) begin
                            state_next = EXT;
                        end else if (wait_of[sel_idx] == 4'd0) begin
                            state_next = ACK;
                            {dsack1_n_next, dsack0_n_next} = port_strobes(port_of[sel_idx]);
                        end else begin
                            state_next    = WAIT;
                            wait_cnt_next = wait_of[sel_idx];
                        end
                    end
                end
            end
            WAIT: begin
                if (AS_n) begin
                    state_next = IDLE;
                end else begin
                    wdog_next = wdog_inc;
                    if (chan_valid_reg) begin
                        wait_cnt_next = wait_cnt_reg - 4'd1;
                    end
                    // Acknowledge beats a watchdog expiry on the same edge.
                    if (chan_valid_reg && wait_cnt_reg == 4'd1) begin
                        state_next = ACK;
                        {dsack1_n_next, dsack0_n_next} = port_strobes(port_of[chan_reg]);
                    end else if (wdog_inc == TIMEOUT) begin
                        state_next  = TERM;
                        berr_n_next = 1'b0;
                    end
                end
            end
            EXT: begin
                if (AS_n) begin
                    state_next = IDLE;
                end else begin
                    wdog_next = wdog_inc;
                    if (!EXT_DSACK0_n || !EXT_DSACK1_n) begin
                        state_next    = ACK;
                        dsack0_n_next = EXT_DSACK0_n;
                        dsack1_n_next = EXT_DSACK1_n;
                    end else if (wdog_inc == TIMEOUT) begin
                        state_next  = TERM;
                        berr_n_next = 1'b0;
                    end
                end
            end
            ACK, TERM: begin
                if (AS_n) begin
                    state_next    = IDLE;
                    dsack0_n_next = 1'b1;
                    dsack1_n_next = 1'b1;
                    berr_n_next   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= 4'd0;
            wdog_reg       <= 8'd0;
            chan_reg       <= '0;
            chan_valid_reg <= 1'b0;
            as_prev_reg    <= 1'b0;
            dsack0_n_reg   <= 1'b1;
            dsack1_n_reg   <= 1'b1;
            berr_n_reg     <= 1'b1;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            wdog_reg       <= wdog_next;
            chan_reg       <= chan_next;
            chan_valid_reg <= chan_valid_next;
            as_prev_reg    <= AS_n;
            dsack0_n_reg   <= dsack0_n_next;
            dsack1_n_reg   <= dsack1_n_next;
            berr_n_reg     <= berr_n_next;
        end
    end

    assign DSACK0_n = dsack0_n_reg;
    assign DSACK1_n = dsack1_n_reg;
    assign BERR_n   = berr_n_reg;
    assign BUSY     = (state_reg != IDLE);

endmodule
